// File: rtl/snes_button_events.sv
// Debounces the SNES button vector once per poll frame and queues press/release events in a FWFT FIFO.
// Optional `SNES_EVT_TIMESTAMP_EN tags each event with the 8-bit frame count of its committing frame.
module snes_button_events #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned FIFO_AW         = 3,
`ifdef SNES_EVT_TIMESTAMP_EN
  localparam int unsigned TS_W           = 8,
`else
  localparam int unsigned TS_W           = 0,
`endif
  localparam int unsigned EVT_W          = TS_W + 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [11:0]        button_data,
  input  logic               data_latch,
  input  logic               rd_en,
  input  logic               clr_overflow,
  output logic [EVT_W-1:0]   evt_data,
  output logic               evt_valid,
  output logic [FIFO_AW:0]   evt_count,
  output logic               overflow,
  output logic [11:0]        buttons
);

  localparam int unsigned NB    = 12;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PTR_W = FIFO_AW;
  localparam int unsigned OCC_W = FIFO_AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FIFO_DEPTH);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_latch_q;
  logic              w_frame;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [NB-1:0]     r_candidate;
  logic [NB-1:0]     w_cand_nxt;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [NB-1:0]     r_stable;
  logic [NB-1:0]     w_stable_nxt;
  logic [NB-1:0]     r_diff;
  logic [NB-1:0]     w_diff_nxt;
  logic              w_commit;
  logic              w_push;
  logic [EVT_W-1:0]  w_push_data;

  logic [EVT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [OCC_W-1:0]  r_count;
  logic [OCC_W-1:0]  w_count_nxt;
  logic              r_evt_valid;
  logic [EVT_W-1:0]  r_evt_data;
  logic [EVT_W-1:0]  w_head_nxt;
  logic              r_overflow;
  logic              w_full;
  logic              w_do_pop;
  logic              w_do_push;
  logic              w_drop;

`ifdef SNES_EVT_TIMESTAMP_EN
  logic [7:0]        r_frame_cnt;
  logic [7:0]        r_ts;
`endif

  assign w_frame = data_latch & ~r_latch_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Debounce and scan sequencing; frames outside IDLE leave debounce state untouched
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cand_nxt   = r_candidate;
    w_cnt_nxt    = r_match_cnt;
    w_stable_nxt = r_stable;
    w_diff_nxt   = r_diff;
    w_commit     = 1'b0;
    w_push       = 1'b0;
    w_push_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame) begin
          if (button_data == r_candidate) begin
            w_cnt_nxt = (r_match_cnt >= DEB_MAX) ? DEB_MAX : r_match_cnt + CNT_W'(1);
          end else begin
            w_cand_nxt = button_data;
            w_cnt_nxt  = CNT_W'(1);
          end
          if ((w_cnt_nxt == DEB_MAX) && (w_cand_nxt != r_stable)) begin
            w_commit     = 1'b1;
            w_diff_nxt   = w_cand_nxt ^ r_stable;
            w_stable_nxt = w_cand_nxt;
            w_idx_nxt    = '0;
            w_state_nxt  = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        w_push = r_diff[r_idx];
`ifdef SNES_EVT_TIMESTAMP_EN
        w_push_data = {r_ts, r_stable[r_idx], r_idx};
`else
        w_push_data = {r_stable[r_idx], r_idx};
`endif
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_q   <= 1'b0;
      r_idx       <= '0;
      r_candidate <= '0;
      r_match_cnt <= '0;
      r_stable    <= '0;
      r_diff      <= '0;
    end else begin
      r_latch_q   <= data_latch;
      r_idx       <= w_idx_nxt;
      r_candidate <= w_cand_nxt;
      r_match_cnt <= w_cnt_nxt;
      r_stable    <= w_stable_nxt;
      r_diff      <= w_diff_nxt;
    end
  end

`ifdef SNES_EVT_TIMESTAMP_EN
  // Frame counter advances on every strobe, ignored ones included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_ts        <= '0;
    end else begin
      if (w_frame) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_commit) begin
        r_ts <= r_frame_cnt;
      end
    end
  end
`endif

  // FIFO control: a pop frees the slot a same-cycle push needs when full
  always_comb begin
    w_full       = (r_count == FULL_CNT);
    w_do_pop     = rd_en & r_evt_valid;
    w_do_push    = w_push & (~w_full | w_do_pop);
    w_drop       = w_push & w_full & ~w_do_pop;
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);
    w_count_nxt  = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + OCC_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - OCC_W'(1);
    end
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_do_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = w_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_evt_valid <= (w_count_nxt != '0);
      r_evt_data  <= w_head_nxt;
      // A drop outranks a same-cycle clear
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign evt_data  = r_evt_data;
  assign evt_valid = r_evt_valid;
  assign evt_count = r_count;
  assign overflow  = r_overflow;
  assign buttons   = r_stable;

endmodule
